// File: rtl/model_vertex_transform_pkg.sv
// Shared fixed-point constants and FSM state type for the vertex transform stages.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package model_vertex_transform_pkg;

  localparam int VT_WOI = 8;
  localparam int VT_WOF = 8;
  localparam int VT_WW  = VT_WOI + VT_WOF;
  localparam int VT_ACCW = 2 * VT_WW + 4;

  // Column of the model matrix holding the translation term of each row.
  localparam int TCOL = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } vt_state_t;

endpackage

// File: rtl/model_vertex_transform_fxp_round_sat.sv
// Rounds a wide Q(2I).(2F) accumulator to Q(I).(F), half toward +inf, then saturates.
// Latency: combinational.
// Backpressure: none; pure function of its input.
module fxp_round_sat #(
  parameter int ACCW = 36,
  parameter int WI   = 8,
  parameter int WF   = 8
) (
  input  logic signed [ACCW-1:0]  din,
  output logic        [WI+WF-1:0] dout,
  output logic                    ovf
);

  localparam int W = WI + WF;
  localparam logic signed [ACCW-1:0] MAXV = {{(ACCW-W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [ACCW-1:0] MINV = {{(ACCW-W+1){1'b1}}, {(W-1){1'b0}}};

  logic signed [ACCW-1:0] biased;
  logic signed [ACCW-1:0] shifted;

  always_comb begin
    biased  = din + (ACCW'(1) << (WF - 1));
    shifted = biased >>> WF;
    dout    = shifted[W-1:0];
    ovf     = 1'b0;
    if (shifted > MAXV) begin
      dout = MAXV[W-1:0];
      ovf  = 1'b1;
    end else if (shifted < MINV) begin
      dout = MINV[W-1:0];
      ovf  = 1'b1;
    end
  end

endmodule

// File: rtl/model_vertex_transform.sv
// Applies a snapshotted 4x4 model matrix (row 3 = 0,0,0,1) to one vertex using a single shared MAC.
// Latency: out_valid 9 cycles after the accept edge; at most one vertex per 11 cycles.
// Backpressure: result held in OUT until out_ready; in_ready low from accept until that handshake.
module model_vertex_transform
  import model_vertex_transform_pkg::*;
#(
  parameter int WOI  = VT_WOI,
  parameter int WOF  = VT_WOF,
  parameter int ACCW = 2 * (WOI + WOF) + 4
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic [15:0][WOI+WOF-1:0]      model_matrix,
  input  logic [WOI+WOF-1:0]            in_x,
  input  logic [WOI+WOF-1:0]            in_y,
  input  logic [WOI+WOF-1:0]            in_z,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [WOI+WOF-1:0]            out_x,
  output logic [WOI+WOF-1:0]            out_y,
  output logic [WOI+WOF-1:0]            out_z,
  output logic [2:0]                    out_ovf,
  output logic                          out_valid,
  input  logic                          out_ready
);

  localparam int W = WOI + WOF;

  vt_state_t state, state_nxt;

  logic [11:0][W-1:0]     mreg;
  logic [2:0][W-1:0]      vreg;
  logic signed [ACCW-1:0] acc;
  logic [1:0]             row;
  logic [1:0]             col;

  logic [3:0]             midx;
  logic [3:0]             tidx;
  logic signed [2*W-1:0]  prod;
  logic signed [ACCW-1:0] prod_ext;
  logic signed [ACCW-1:0] trans_ext;
  logic signed [ACCW-1:0] sum;
  logic signed [ACCW-1:0] fin;
  logic [W-1:0]           rs_dat;
  logic                   rs_ovf;
  logic                   unused_mat;

  // Row 3 of the matrix is implied, so entries 12..15 are never read.
  assign unused_mat = ^model_matrix[15:12];

  assign midx = {row, col};
  assign tidx = {row, 2'(TCOL)};

  always_comb begin
    prod      = $signed(mreg[midx]) * $signed(vreg[col]);
    prod_ext  = {{(ACCW-2*W){prod[2*W-1]}}, prod};
    trans_ext = {{(ACCW-W-WOF){mreg[tidx][W-1]}}, mreg[tidx], {WOF{1'b0}}};
    sum       = acc + prod_ext;
    fin       = sum + trans_ext;
  end

  fxp_round_sat #(
    .ACCW (ACCW),
    .WI   (WOI),
    .WF   (WOF)
  ) u_round_sat (
    .din  (fin),
    .dout (rs_dat),
    .ovf  (rs_ovf)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = MAC;
      MAC:     if (row == 2'd2 && col == 2'd2) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      mreg    <= '0;
      vreg    <= '0;
      acc     <= '0;
      row     <= '0;
      col     <= '0;
      out_x   <= '0;
      out_y   <= '0;
      out_z   <= '0;
      out_ovf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mreg    <= model_matrix[11:0];
            vreg    <= {in_z, in_y, in_x};
            acc     <= '0;
            row     <= '0;
            col     <= '0;
            out_ovf <= '0;
          end
        end
        MAC: begin
          if (col == 2'd2) begin
            // Row complete: fold in translation, round into that coordinate.
            case (row)
              2'd0:    begin out_x <= rs_dat; out_ovf[0] <= rs_ovf; end
              2'd1:    begin out_y <= rs_dat; out_ovf[1] <= rs_ovf; end
              default: begin out_z <= rs_dat; out_ovf[2] <= rs_ovf; end
            endcase
            acc <= '0;
            col <= '0;
            row <= row + 2'd1;
          end else begin
            acc <= sum;
            col <= col + 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_model_vertex_transform.sv
// Directed-vector bench for model_vertex_transform with hand-computed results.
module tb_model_vertex_transform;

  logic              Clk = 1'b0;
  logic              Reset;
  logic [15:0][15:0] model_matrix;
  logic [15:0]       in_x, in_y, in_z;
  logic              in_valid;
  logic              in_ready;
  logic [15:0]       out_x, out_y, out_z;
  logic [2:0]        out_ovf;
  logic              out_valid;
  logic              out_ready;

  int vecs = 0;
  int errs = 0;

  model_vertex_transform dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .model_matrix (model_matrix),
    .in_x         (in_x),
    .in_y         (in_y),
    .in_z         (in_z),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out_x        (out_x),
    .out_y        (out_y),
    .out_z        (out_z),
    .out_ovf      (out_ovf),
    .out_valid    (out_valid),
    .out_ready    (out_ready)
  );

  always #5 Clk = ~Clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [15:0][15:0] diag(input logic [15:0] d);
    logic [15:0][15:0] m = '0;
    m[0]  = d;
    m[5]  = d;
    m[10] = d;
    m[15] = 16'h0100;
    return m;
  endfunction

  // Accept one vertex, check latency and result, optionally stall and/or zero the matrix.
  task automatic run_vec(input string tag,
                         input logic [15:0] x, input logic [15:0] y, input logic [15:0] z,
                         input logic [15:0] ex, input logic [15:0] ey, input logic [15:0] ez,
                         input logic [2:0] eovf, input int hold, input bit zero_after);
    int lat;
    int wait_cnt;
    bit rdy_seen;
    in_x = x; in_y = y; in_z = z;
    wait_cnt = 0;
    while (!in_ready && wait_cnt < 30) begin
      tick();
      wait_cnt++;
    end
    check_val({tag, " in_ready before accept"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    if (zero_after) model_matrix = '0;
    in_x = 16'hDEAD; in_y = 16'hBEEF; in_z = 16'h1234;
    lat = 0;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 20) begin
      if (in_ready) rdy_seen = 1'b1;
      tick();
      lat++;
    end
    check_val({tag, " latency"}, 32'(lat), 32'd9);
    check_val({tag, " in_ready low in MAC"}, 32'(rdy_seen), 32'd0);
    check_val({tag, " out_x"}, 32'(out_x), 32'(ex));
    check_val({tag, " out_y"}, 32'(out_y), 32'(ey));
    check_val({tag, " out_z"}, 32'(out_z), 32'(ez));
    check_val({tag, " out_ovf"}, 32'(out_ovf), 32'(eovf));
    for (int i = 0; i < hold; i++) begin
      tick();
      check_val({tag, " hold valid/ready"}, {30'd0, out_valid, in_ready}, 32'b10);
      check_val({tag, " hold data"}, {out_x, out_y}, {ex, ey});
      check_val({tag, " hold z"}, 32'(out_z), 32'(ez));
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_val({tag, " after handshake valid/ready"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [15:0][15:0] m;
    bit stray;
    Reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0; in_y = '0; in_z = '0;
    model_matrix = diag(16'h0100);
    tick();
    tick();
    Reset = 1'b0;
    check_val("reset out_valid", 32'(out_valid), 32'd0);
    check_val("reset in_ready", 32'(in_ready), 32'd1);
    check_val("reset out_xyz", {out_x, out_y}, 32'd0);
    check_val("reset out_z/ovf", {13'd0, out_ovf, out_z}, 32'd0);

    model_matrix = diag(16'h0100);
    run_vec("ident", 16'h0100, 16'h0200, 16'hFD00, 16'h0100, 16'h0200, 16'hFD00, 3'b000, 0, 0);

    m = diag(16'h0200);
    m[3] = 16'h0080;
    model_matrix = m;
    run_vec("scale2", 16'h0180, 16'h0100, 16'h0100, 16'h0380, 16'h0200, 16'h0200, 3'b000, 0, 0);

    // x' = x + y + 1, y' = y + z, z' = 0.5z - 1
    m = '0;
    m[0] = 16'h0100; m[1] = 16'h0100; m[3] = 16'h0100;
    m[5] = 16'h0100; m[6] = 16'h0100;
    m[10] = 16'h0080; m[11] = 16'hFF00;
    model_matrix = m;
    run_vec("bp_snap", 16'h0100, 16'h0200, 16'h0400, 16'h0400, 16'h0600, 16'h0100, 3'b000, 5, 1);

    m = diag(16'h0100);
    m[0] = 16'h7F00;
    model_matrix = m;
    run_vec("sat_pos", 16'h7F00, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 3'b001, 0, 0);
    model_matrix = m;
    run_vec("sat_neg", 16'h8100, 16'h0000, 16'h0000, 16'h8000, 16'h0000, 16'h0000, 3'b001, 0, 0);
    model_matrix = diag(16'h0100);
    run_vec("ovf_clear", 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 16'h0100, 3'b000, 0, 0);

    m = '0;
    m[0] = 16'h0001;
    model_matrix = m;
    run_vec("round_up", 16'h0080, 16'h0000, 16'h0000, 16'h0001, 16'h0000, 16'h0000, 3'b000, 0, 0);
    model_matrix = m;
    run_vec("round_neg", 16'hFF80, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'b000, 0, 0);

    // Reset on the 4th MAC edge: row 0 already written, then everything discarded.
    model_matrix = diag(16'h0100);
    in_x = 16'h0500; in_y = 16'h0600; in_z = 16'h0700;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    check_val("mid-mac row0", 32'(out_x), 32'h0500);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    check_val("mid-mac reset valid/ready", {30'd0, out_valid, in_ready}, 32'b01);
    check_val("mid-mac reset out_xy", {out_x, out_y}, 32'd0);
    check_val("mid-mac reset z/ovf", {13'd0, out_ovf, out_z}, 32'd0);
    stray = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) stray = 1'b1;
      tick();
    end
    check_val("no output after reset", 32'(stray), 32'd0);
    model_matrix = diag(16'h0100);
    run_vec("post_reset", 16'h0300, 16'hFF00, 16'h0040, 16'h0300, 16'hFF00, 16'h0040, 3'b000, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/model_vertex_transform.md
Name: model_vertex_transform

Overview:
- Sequential consumer of the 4x4 model matrix produced by the model-matrix generator.
- Applies the matrix to a stream of object-space vertices (x, y, z, implicit w=1) and emits world-space vertices.
- Sits between vertex fetch and the view/projection stage.
- Uses a single time-multiplexed multiply-accumulate unit to save DSPs, with valid/ready handshakes on both sides.

Parameters:
- WOI, 8, integer bits of matrix entries and of vertex in/out coordinates (signed fixed point)
- WOF, 8, fractional bits of matrix entries and of vertex coordinates
- ACCW, 2*(WOI+WOF)+4, accumulator width (full-precision products plus guard bits)

Ports:
- Clk  in  1  system clock; the single clock domain.
- Reset  in  1  synchronous, active-high reset.
- model_matrix  in  16x(WOI+WOF)  row-major matrix, flat index r*4+c; entries 12..15 are ignored (row 3 is fixed at 0,0,0,1).
- in_x, in_y, in_z  in  WOI+WOF each  object-space vertex, signed Q(WOI).(WOF).
- in_valid  in  1  vertex and matrix present.
- in_ready  out  1  block can accept a vertex.
- out_x, out_y, out_z  out  WOI+WOF each  transformed vertex.
- out_ovf  out  3  per-coordinate saturation flags, bit0=x, bit1=y, bit2=z.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE; out_valid=0; in_ready=1 on the following cycle.
  - out_x/out_y/out_z=0; out_ovf=0; accumulator and counters cleared.
  - Reset overrides every other input, including mid-MAC and in OUT; any in-flight vertex is discarded with no output.
- States: IDLE, MAC, OUT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at edge N: snapshot in_x/y/z and matrix entries 0..11 into internal registers, clear the accumulator, set row=0 and col=0, go to MAC.
  - Matrix changes after acceptance do not affect the result.
- MAC:
  - in_ready=0; one MAC per cycle, nine cycles total, at edges N+1..N+9.
  - Each cycle: acc += M[row*4+col] * v[col], where v = (x, y, z). Signed full-precision product, Q(2*WOI).(2*WOF), sign-extended to ACCW.
  - When col==2, the final value is acc + M[row*4+3] << WOF, i.e. translation sign-extended and aligned to 2*WOF fractional bits.
  - That final value is rounded and saturated into the out register for that row, and its out_ovf bit is set. acc is cleared and row is incremented.
  - After row 2 completes (edge N+9): go to OUT.
- OUT:
  - out_valid=1 from after edge N+9; fixed latency is 9 cycles from acceptance to out_valid.
  - out_* are held stable while out_valid && !out_ready.
  - On out_valid&&out_ready: go to IDLE, out_valid=0. in_ready is high the next cycle, so throughput is at most one vertex per 11 cycles.
  - out_* keep their last value after the handshake; they are only meaningful while out_valid=1.
- Round/saturate (per row):
  - Add 2^(WOF-1), then arithmetic shift right by WOF (round half toward +inf).
  - Clamp to [-2^(WOI+WOF-1), 2^(WOI+WOF-1)-1]; the ovf bit is 1 iff clamping occurred.
- out_ovf is per vertex: all bits are cleared on each new acceptance.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Decomposition:
- Shared package: fixed-point width constants (WOI, WOF, derived word width), a state enum typedef (IDLE, MAC, OUT), and a matrix index constant for the translation column.
- One sub-module, fxp_round_sat: combinational ACCW to WOI+WOF round-half-up and saturate, with an overflow output. It is reusable by the later view/projection transform stages.
- Counters, FSM and MAC stay in the top module.

Test Plan:
- Identity matrix, zero translation, vertex (0x0100, 0x0200, 0xFD00) → out (0x0100, 0x0200, 0xFD00), out_ovf=000, out_valid rises exactly 9 cycles after the accept edge.
- Diagonal 0x0200 (scale 2), translate x=0x0080, vertex (0x0180, 0x0100, 0x0100) → out (0x0380, 0x0200, 0x0200).
- Back-pressure and snapshot:
  - Stimulus: hold out_ready=0 for 5 cycles in OUT, and change model_matrix to all-zero right after the accept.
  - Required response: out_* stay stable with the original-matrix result; in_ready=0 throughout; in_ready=1 one cycle after the handshake.
- Saturation:
  - M[0]=0x7F00 with in_x=0x7F00 → out_x=0x7FFF, out_ovf[0]=1.
  - Same M[0] with in_x=0x8100 → out_x=0x8000, out_ovf[0]=1.
  - Next vertex with identity matrix → out_ovf=000.
- Rounding: M[0]=0x0001, other entries 0.
  - in_x=0x0080 → out_x=0x0001 (half LSB rounds up).
  - in_x=0xFF80 → out_x=0x0000.
- Reset asserted during MAC (4th MAC cycle) → out_valid=0 and out_* = 0 after the edge, in_ready=1 the following cycle, no result ever emitted for that vertex; a fresh vertex then completes normally.
